// File: rtl/ar_br_cr_datapath.sv
// AR/BR/CR datapath: rising-edge command decode, shift/clear ops on CR,
// AR status decode, and a valid/ready result port with overrun/overflow flags.
module ar_br_cr_datapath #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_b,
   input  logic [WIDTH-1:0]     data_a,
   input  logic [WIDTH-1:0]     data_b,
   input  logic                 load_AR_BR,
   input  logic                 div_AR_T_CR,
   input  logic                 mul_BR_T_CR,
   input  logic                 clr_CR,
   output logic                 AR_neg,
   output logic                 AR_pos,
   output logic                 AR_zero,
   output logic [WIDTH-1:0]     cr_data,
   output logic                 cr_valid,
   input  logic                 cr_ready,
   output logic                 ovf,
   output logic                 overrun,
   output logic [CNT_WIDTH-1:0] op_count
);

   logic [WIDTH-1:0]     ar_q, ar_d;
   logic [WIDTH-1:0]     br_q, br_d;
   logic [WIDTH-1:0]     cr_q, cr_d;
   logic                 valid_q, valid_d;
   logic                 ovf_q, ovf_d;
   logic                 overrun_q, overrun_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [3:0]           cmd_q;

   logic load_go, clr_go, div_go, mul_go, cr_op;
   logic [3:0] cmd_now, cmd_rise;

   // Bit order {load, clr, div, mul} matches execution priority.
   assign cmd_now  = {load_AR_BR, clr_CR, div_AR_T_CR, mul_BR_T_CR};
   assign cmd_rise = cmd_now & ~cmd_q;

   assign load_go = cmd_rise[3];
   assign clr_go  = cmd_rise[2] & ~cmd_rise[3];
   assign div_go  = cmd_rise[1] & ~cmd_rise[3] & ~cmd_rise[2];
   assign mul_go  = cmd_rise[0] & ~cmd_rise[3] & ~cmd_rise[2] & ~cmd_rise[1];
   assign cr_op   = clr_go | div_go | mul_go;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path infers a latch.
      ar_d      = ar_q;
      br_d      = br_q;
      cr_d      = cr_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      overrun_d = overrun_q;
      cnt_d     = cnt_q;

      if (load_go) begin
         ar_d = data_a;
         br_d = data_b;
      end

      if (clr_go) cr_d = '0;
      if (div_go) cr_d = {ar_q[WIDTH-1], ar_q[WIDTH-1:1]};
      if (mul_go) begin
         cr_d = {br_q[WIDTH-2:0], 1'b0};
         if (br_q[WIDTH-1] != br_q[WIDTH-2]) ovf_d = 1'b1;
      end

      // A new result wins over a concurrent transfer; it is only lost when unaccepted.
      if (cr_op) begin
         valid_d = 1'b1;
         cnt_d   = cnt_q + CNT_WIDTH'(1);
         if (valid_q && !cr_ready) overrun_d = 1'b1;
      end else if (valid_q && cr_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         ar_q      <= '0;
         br_q      <= '0;
         cr_q      <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         overrun_q <= 1'b0;
         cnt_q     <= '0;
         cmd_q     <= '0;
      end else begin
         ar_q      <= ar_d;
         br_q      <= br_d;
         cr_q      <= cr_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         overrun_q <= overrun_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_now;
      end
   end

   assign AR_neg   = ar_q[WIDTH-1];
   assign AR_zero  = (ar_q == '0);
   assign AR_pos   = !ar_q[WIDTH-1] && (ar_q != '0);
   assign cr_data  = cr_q;
   assign cr_valid = valid_q;
   assign ovf      = ovf_q;
   assign overrun  = overrun_q;
   assign op_count = cnt_q;

endmodule

// File: tb/tb_ar_br_cr_datapath.sv
// Directed bench for ar_br_cr_datapath: expected CR results go into a queue
// that a concurrent monitor drains on every accepted transfer.
module tb_ar_br_cr_datapath;

   logic       clk = 1'b0;
   logic       reset_b;
   logic [7:0] data_a, data_b;
   logic       load_AR_BR, div_AR_T_CR, mul_BR_T_CR, clr_CR;
   logic       AR_neg, AR_pos, AR_zero;
   logic [7:0] cr_data;
   logic       cr_valid, cr_ready;
   logic       ovf, overrun;
   logic [7:0] op_count;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   ar_br_cr_datapath #(.WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk(clk), .reset_b(reset_b),
      .data_a(data_a), .data_b(data_b),
      .load_AR_BR(load_AR_BR), .div_AR_T_CR(div_AR_T_CR),
      .mul_BR_T_CR(mul_BR_T_CR), .clr_CR(clr_CR),
      .AR_neg(AR_neg), .AR_pos(AR_pos), .AR_zero(AR_zero),
      .cr_data(cr_data), .cr_valid(cr_valid), .cr_ready(cr_ready),
      .ovf(ovf), .overrun(overrun), .op_count(op_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 0=load 1=clr 2=div 3=mul; raises the command and lets one edge sample it.
   task automatic fire(input int which);
      case (which)
         0: load_AR_BR  = 1'b1;
         1: clr_CR      = 1'b1;
         2: div_AR_T_CR = 1'b1;
         default: mul_BR_T_CR = 1'b1;
      endcase
      tick();
   endtask

   task automatic rel();
      load_AR_BR  = 1'b0;
      clr_CR      = 1'b0;
      div_AR_T_CR = 1'b0;
      mul_BR_T_CR = 1'b0;
      tick();
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] b);
      data_a = a;
      data_b = b;
      fire(0);
      rel();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ar_zero"}, AR_zero, 1);
      check({tag, "_ar_neg"}, AR_neg, 0);
      check({tag, "_ar_pos"}, AR_pos, 0);
      check({tag, "_cr_valid"}, cr_valid, 0);
      check({tag, "_cr_data"}, cr_data, 0);
      check({tag, "_op_count"}, op_count, 0);
      check({tag, "_ovf"}, ovf, 0);
      check({tag, "_overrun"}, overrun, 0);
   endtask

   initial begin
      int vcnt;
      reset_b = 1'b0;
      data_a = '0; data_b = '0;
      load_AR_BR = 0; div_AR_T_CR = 0; mul_BR_T_CR = 0; clr_CR = 0;
      cr_ready = 1'b1;

      fork
         forever begin
            @(negedge clk);
            if (reset_b && cr_valid && cr_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_transfer actual=%0h required=none", cr_data);
               end else begin
                  check("cr_transfer", cr_data, exp_q.pop_front());
               end
            end
         end
      join_none

      tick(); tick();
      check_reset_state("rst");
      reset_b = 1'b1;
      tick();

      // -10 / 2 rounds toward minus infinity.
      load(8'hF6, 8'h05);
      check("neg_after_load", AR_neg, 1);
      check("pos_after_load", AR_pos, 0);
      check("zero_after_load", AR_zero, 0);
      exp_q.push_back(8'hFB);
      fire(2);
      check("div_cr", cr_data, 8'hFB);
      check("div_valid", cr_valid, 1);
      check("div_count", op_count, 1);
      rel();

      load(8'hF6, 8'h50);
      exp_q.push_back(8'hA0);
      fire(3);
      check("mul_ovf_cr", cr_data, 8'hA0);
      check("mul_ovf_set", ovf, 1);
      rel();
      load(8'hF6, 8'h20);
      exp_q.push_back(8'h40);
      fire(3);
      check("mul_cr", cr_data, 8'h40);
      check("ovf_sticky", ovf, 1);
      rel();
      check("mul_count", op_count, 3);

      load(8'hFB, 8'h20);
      exp_q.push_back(8'hFD);
      fire(2);
      check("div_m5", cr_data, 8'hFD);
      rel();

      // Held-high command executes once.
      exp_q.push_back(8'h40);
      vcnt = 0;
      mul_BR_T_CR = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (cr_valid) vcnt++;
      end
      rel();
      check("hold_valid_cycles", vcnt, 1);
      check("hold_count", op_count, 5);

      // Overwrite of an unaccepted result.
      cr_ready = 1'b0;
      load(8'h08, 8'h20);
      fire(1);
      rel();
      check("clr_pending_valid", cr_valid, 1);
      check("clr_pending_cr", cr_data, 0);
      check("no_overrun_yet", overrun, 0);
      exp_q.push_back(8'h04);
      fire(2);
      check("overrun_cr", cr_data, 8'h04);
      check("overrun_set", overrun, 1);
      check("overrun_valid", cr_valid, 1);
      rel();
      check("overrun_count", op_count, 7);
      cr_ready = 1'b1;
      tick(); tick();

      // Asynchronous reset between edges.
      #2 reset_b = 1'b0;
      #1 check_reset_state("async_rst");
      exp_q.delete();
      @(posedge clk);
      #1 reset_b = 1'b1;
      tick();

      // New op coinciding with a transfer.
      cr_ready = 1'b0;
      load(8'h08, 8'h20);
      exp_q.push_back(8'h00);
      fire(1);
      rel();
      exp_q.push_back(8'h04);
      cr_ready = 1'b1;
      fire(2);
      check("coinc_overrun", overrun, 0);
      check("coinc_valid", cr_valid, 1);
      check("coinc_cr", cr_data, 8'h04);
      check("coinc_count", op_count, 2);
      rel();

      // Simultaneous load and clr rises: only load executes.
      data_a = 8'h7F;
      data_b = 8'h01;
      load_AR_BR = 1'b1;
      clr_CR = 1'b1;
      tick();
      check("prio_ar_pos", AR_pos, 1);
      check("prio_count", op_count, 2);
      check("prio_valid", cr_valid, 0);
      check("prio_cr", cr_data, 8'h04);
      load_AR_BR = 1'b0;
      tick();
      check("prio_held_clr", op_count, 2);
      clr_CR = 1'b0;
      tick();
      exp_q.push_back(8'h00);
      clr_CR = 1'b1;
      tick();
      check("prio_reclr_count", op_count, 3);
      check("prio_reclr_cr", cr_data, 8'h00);
      rel();

      // Counter wrap over 256 ops from a fresh reset.
      reset_b = 1'b0;
      tick();
      reset_b = 1'b1;
      tick();
      load(8'h7F, 8'h01);
      for (int i = 0; i < 256; i++) begin
         if (i % 2 == 0) begin
            exp_q.push_back(8'h00);
            fire(1);
         end else begin
            exp_q.push_back(8'h3F);
            fire(2);
         end
         rel();
         if (i == 254) check("count_255", op_count, 255);
      end
      check("count_wrap", op_count, 0);

      tick(); tick();
      check("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ar_br_cr_datapath.md
# ar_br_cr_datapath

Datapath stage driven by the AR/BR/CR controller. It holds operand registers AR and BR and result register CR, and executes load, divide, multiply and clear commands. It returns the AR sign/zero status the controller branches on. Each CR result is presented to the downstream consumer through a valid/ready handshake, with overrun and overflow reporting.

## Interface
- WIDTH, 8, bit width of AR, BR, CR and data inputs (two's complement, WIDTH >= 2)
- CNT_WIDTH, 8, width of the executed-operation counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_b  input  1  asynchronous active-low reset
- data_a  input  WIDTH  operand loaded into AR
- data_b  input  WIDTH  operand loaded into BR
- load_AR_BR  input  1  controller command: load AR/BR
- div_AR_T_CR  input  1  controller command: CR <= AR / 2
- mul_BR_T_CR  input  1  controller command: CR <= BR * 2
- clr_CR  input  1  controller command: CR <= 0
- AR_neg  output  1  AR[WIDTH-1] == 1
- AR_pos  output  1  AR != 0 and AR[WIDTH-1] == 0
- AR_zero  output  1  AR == 0
- cr_data  output  WIDTH  current CR contents
- cr_valid  output  1  CR holds a result not yet accepted
- cr_ready  input  1  downstream accepts cr_data when cr_valid is high
- ovf  output  1  sticky: a multiply overflowed
- overrun  output  1  sticky: an unaccepted result was overwritten
- op_count  output  CNT_WIDTH  number of CR-writing operations executed, wraps

## Operation
- Command inputs are level signals; the controller may hold them high indefinitely. Each command is registered every cycle (cmd_q). A command executes only on its rising edge: cmd == 1 and cmd_q == 0 at the sampling clock edge.
- Priority when several rises are detected in the same cycle: load > clr > div > mul. Only the highest-priority rise executes; the lower-priority rises are discarded, not deferred.
- Load: AR <= data_a and BR <= data_b. CR, cr_valid and op_count are unchanged.
- Div: CR <= AR >>> 1, an arithmetic shift that rounds toward minus infinity (-5 -> -3).
- Mul: CR <= BR << 1, truncated to WIDTH. ovf is set if BR[WIDTH-1] != BR[WIDTH-2].
- Clr: CR <= 0. This is a result like any other: it sets cr_valid and counts in op_count.
- Any CR-writing op (div, mul, clr) sets cr_valid = 1 and increments op_count modulo 2^CNT_WIDTH.
- Handshake: a transfer occurs on a clock edge where cr_valid && cr_ready. Without a new op in that cycle, cr_valid clears on that edge.
- If a CR-writing op executes in a cycle where cr_valid && !cr_ready, the old result is lost: CR updates, cr_valid stays 1, and overrun is set.
- If a CR-writing op coincides with a transfer (cr_valid && cr_ready), the old value transfers, the new value loads, cr_valid stays 1, and overrun is not set.
- Status outputs are combinational decodes of the AR register. Exactly one of AR_neg, AR_pos and AR_zero is high at all times.
- ovf and overrun clear only on reset.

## Timing
- Reset (asynchronous assert, synchronous release), effective immediately:
  - AR = BR = CR = 0, all cmd_q = 0
  - cr_valid = 0, ovf = 0, overrun = 0, op_count = 0
  - AR_zero = 1, AR_neg = 0, AR_pos = 0
- Command latency: for a command first sampled high at edge N, registers update at edge N. The new AR status is visible after edge N and is therefore valid for the controller at edge N+1.
- A command held high for K cycles executes once. It must go low for at least one sampled edge before it can execute again.
- A command that is already high when reset deasserts executes at the first edge after reset, because cmd_q = 0.
- cr_data is stable whenever cr_valid is high and no new op executes.
- Reset mid-operation discards everything; no partial state survives.

## Test plan
- Reset with all commands low, WIDTH=8 -> AR_zero=1, cr_valid=0, op_count=0, cr_data=0. Assert reset_b low between edges -> outputs reset without waiting for a clock edge.
- load_AR_BR rises with data_a=0xF6 (-10), data_b=0x05, then div rises -> AR_neg=1 after the load edge. After the div edge: cr_data=0xFB, cr_valid=1, op_count=1.
- Load data_b=0x50, then mul -> cr_data=0xA0, ovf=1. Load data_b=0x20, then mul -> cr_data=0x40, ovf stays 1.
- Hold mul_BR_T_CR high for 5 cycles with cr_ready=1 -> exactly one operation, op_count increments by 1, cr_valid high for exactly one cycle.
- cr_ready=0: clr, then div with AR=0x08 -> cr_data=0x04, overrun=1. Repeat with cr_ready=1 on the second op -> overrun stays 0 and cr_valid stays 1.
- load and clr rise in the same cycle -> only the load executes. CR and op_count are unchanged, and clr_CR must fall and rise again to execute. Also run 256 CR ops -> op_count wraps to 0.
